// File: rtl/reg_rename_file_pkg.sv
// rtl/reg_rename_file_pkg.sv - shared widths and constants for the rename register file
package reg_rename_file_pkg;
  localparam int REG_WIDTH  = 5;
  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;

  localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with per-register ROB rename tags
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int REG_W     = REG_WIDTH,
  parameter int ROB_W     = ROB_WIDTH,
  parameter int DATA_W    = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [REG_W-1:0]  in_commit_reg,
  input  logic [ROB_W-1:0]  in_commit_rob,
  input  logic [DATA_W-1:0] in_commit_value,
  input  logic              in_misbranch,
  input  logic              in_rename_ena,
  input  logic [REG_W-1:0]  in_rename_reg,
  input  logic [ROB_W-1:0]  in_rename_rob,
  input  logic [REG_W-1:0]  in_query_reg1,
  input  logic [REG_W-1:0]  in_query_reg2,
  output logic [DATA_W-1:0] out_value1,
  output logic [ROB_W-1:0]  out_tag1,
  output logic [DATA_W-1:0] out_value2,
  output logic [ROB_W-1:0]  out_tag2
);

  logic [DATA_W-1:0] value_q [REG_COUNT];
  logic [ROB_W-1:0]  tag_q   [REG_COUNT];

  logic commit_hit;
  logic rename_hit;

  assign commit_hit = (in_commit_reg != '0);
  assign rename_hit = in_rename_ena && (in_rename_reg != '0) && !in_misbranch;

  // Rename is applied after the commit tag-clear so it wins on the same register;
  // misbranch clears every tag last. x0 is never written, so it stays 0/0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (ena) begin
      if (commit_hit) begin
        value_q[in_commit_reg] <= in_commit_value;
        if (tag_q[in_commit_reg] == in_commit_rob) begin
          tag_q[in_commit_reg] <= '0;
        end
      end
      if (rename_hit) begin
        tag_q[in_rename_reg] <= in_rename_rob;
      end
      if (in_misbranch) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          tag_q[i] <= '0;
        end
      end
    end
  end

  // Commit bypass is independent of ena so queries always see the retiring value.
  always_comb begin
    out_value1 = value_q[in_query_reg1];
    out_tag1   = tag_q[in_query_reg1];
    if (commit_hit && (in_query_reg1 == in_commit_reg) &&
        (tag_q[in_query_reg1] == in_commit_rob)) begin
      out_value1 = in_commit_value;
      out_tag1   = '0;
    end
  end

  always_comb begin
    out_value2 = value_q[in_query_reg2];
    out_tag2   = tag_q[in_query_reg2];
    if (commit_hit && (in_query_reg2 == in_commit_reg) &&
        (tag_q[in_query_reg2] == in_commit_rob)) begin
      out_value2 = in_commit_value;
      out_tag2   = '0;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - scoreboard bench for reg_rename_file
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [4:0]  in_commit_reg;
  logic [3:0]  in_commit_rob;
  logic [31:0] in_commit_value;
  logic        in_misbranch;
  logic        in_rename_ena;
  logic [4:0]  in_rename_reg;
  logic [3:0]  in_rename_rob;
  logic [4:0]  in_query_reg1;
  logic [4:0]  in_query_reg2;
  logic [31:0] out_value1;
  logic [3:0]  out_tag1;
  logic [31:0] out_value2;
  logic [3:0]  out_tag2;

  typedef struct {
    string       name;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic [31:0] v2;
    logic [3:0]  t2;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_commit_reg(in_commit_reg), .in_commit_rob(in_commit_rob),
    .in_commit_value(in_commit_value), .in_misbranch(in_misbranch),
    .in_rename_ena(in_rename_ena), .in_rename_reg(in_rename_reg),
    .in_rename_rob(in_rename_rob), .in_query_reg1(in_query_reg1),
    .in_query_reg2(in_query_reg2), .out_value1(out_value1), .out_tag1(out_tag1),
    .out_value2(out_value2), .out_tag2(out_tag2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation on every probed cycle.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".value1"}, out_value1, e.v1);
        chk({e.name, ".tag1"},   {28'd0, out_tag1}, {28'd0, e.t1});
        chk({e.name, ".value2"}, out_value2, e.v2);
        chk({e.name, ".tag2"},   {28'd0, out_tag2}, {28'd0, e.t2});
      end
    end
  end

  task automatic idle();
    in_commit_reg   = '0;
    in_commit_rob   = ZERO_ROB;
    in_commit_value = ZERO_DATA;
    in_misbranch    = FALSE;
    in_rename_ena   = FALSE;
    in_rename_reg   = '0;
    in_rename_rob   = ZERO_ROB;
    in_query_reg1   = '0;
    in_query_reg2   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
    idle();
  endtask

  task automatic expect_q(input string name,
                          input logic [4:0] r1, input logic [31:0] v1, input logic [3:0] t1,
                          input logic [4:0] r2, input logic [31:0] v2, input logic [3:0] t2);
    exp_t e;
    in_query_reg1 = r1;
    in_query_reg2 = r2;
    e.name = name; e.v1 = v1; e.t1 = t1; e.v2 = v2; e.t2 = t2;
    exp_q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] rob, input logic [31:0] v);
    in_commit_reg = r; in_commit_rob = rob; in_commit_value = v;
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] rob);
    in_rename_ena = 1'b1; in_rename_reg = r; in_rename_rob = rob;
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b1;

    expect_q("reset", 5'd5, 32'h0, 4'd0, 5'd31, 32'h0, 4'd0);
    tick();

    rename(5'd3, 4'd4);
    tick();
    expect_q("renamed_x3", 5'd3, 32'h0, 4'd4, 5'd0, 32'h0, 4'd0);
    tick();
    commit(5'd3, 4'd4, 32'hDEAD_BEEF);
    expect_q("bypass_x3", 5'd3, 32'hDEAD_BEEF, 4'd0, 5'd3, 32'hDEAD_BEEF, 4'd0);
    tick();
    expect_q("state_x3", 5'd3, 32'hDEAD_BEEF, 4'd0, 5'd0, 32'h0, 4'd0);
    tick();

    rename(5'd3, 4'd4);
    tick();
    rename(5'd3, 4'd7);
    expect_q("waw_tag4", 5'd3, 32'hDEAD_BEEF, 4'd4, 5'd0, 32'h0, 4'd0);
    tick();
    commit(5'd3, 4'd4, 32'h11);
    expect_q("waw_stale_nobypass", 5'd3, 32'hDEAD_BEEF, 4'd7, 5'd0, 32'h0, 4'd0);
    tick();
    expect_q("waw_keep7", 5'd3, 32'h11, 4'd7, 5'd0, 32'h0, 4'd0);
    tick();
    commit(5'd3, 4'd7, 32'h22);
    expect_q("waw_bypass", 5'd3, 32'h22, 4'd0, 5'd0, 32'h0, 4'd0);
    tick();
    expect_q("waw_clear", 5'd3, 32'h22, 4'd0, 5'd0, 32'h0, 4'd0);
    tick();

    commit(5'd6, 4'd2, 32'h55);
    rename(5'd6, 4'd9);
    expect_q("same_cycle_pre", 5'd6, 32'h0, 4'd0, 5'd3, 32'h22, 4'd0);
    tick();
    expect_q("same_cycle_post", 5'd6, 32'h55, 4'd9, 5'd0, 32'h0, 4'd0);
    tick();

    rename(5'd1, 4'd3);
    tick();
    rename(5'd2, 4'd5);
    tick();
    in_misbranch = 1'b1;
    commit(5'd1, 4'd3, 32'h80);
    rename(5'd4, 4'd6);
    expect_q("misbranch_pre", 5'd1, 32'h80, 4'd0, 5'd2, 32'h0, 4'd5);
    tick();
    expect_q("misbranch_x1x2", 5'd1, 32'h80, 4'd0, 5'd2, 32'h0, 4'd0);
    tick();
    expect_q("misbranch_x4x6", 5'd4, 32'h0, 4'd0, 5'd6, 32'h55, 4'd0);
    tick();

    rename(5'd0, 4'd2);
    commit(5'd0, 4'd2, 32'hFF);
    expect_q("x0_same_cycle", 5'd0, 32'h0, 4'd0, 5'd3, 32'h22, 4'd0);
    tick();
    expect_q("x0_after", 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0);
    tick();

    ena = 1'b0;
    rename(5'd7, 4'd3);
    commit(5'd3, 4'd9, 32'h33);
    expect_q("ena_low_pre", 5'd7, 32'h0, 4'd0, 5'd3, 32'h22, 4'd0);
    tick();
    ena = 1'b1;
    expect_q("ena_low_post", 5'd7, 32'h0, 4'd0, 5'd3, 32'h22, 4'd0);
    tick();

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
